// File: rtl/alu_sequencer.sv
// Command/response sequencer that drives a 16-bit ALU, keeps an accumulator and a sticky overflow bit.
// Build option ALU_SEQ_MUL_EN adds op 8: a 16-cycle shift-add multiply performed on the ALU.
module alu_sequencer #(
    parameter logic [15:0] ACC_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_use_acc,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [16:0] alu_res,
    input  logic [1:0]  alu_flag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [16:0] rsp_res,
    output logic [1:0]  rsp_flag,
    output logic [15:0] acc,
    output logic        ovf_sticky,
    input  logic        clr_sticky,
    output logic        busy
);
    localparam logic [3:0] OpNot = 4'd7;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
`ifdef ALU_SEQ_MUL_EN
        StMul,
`endif
        StResp
    } state_e;

    state_e      state;
    logic [15:0] op_a;
    logic        sticky_set;

    assign op_a = cmd_use_acc ? acc : cmd_a;

    // Only a real (supported-op) capture in EXEC may raise the sticky bit.
    assign sticky_set = (state == StExec) && (alu_op <= OpNot) && alu_flag[1];

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpMul = 4'd8;

    // During MUL, alu_a holds the partial product and alu_b holds the shifted multiplicand.
    logic [15:0] b_shift;
    logic [3:0]  mul_cnt;
    logic [15:0] partial_nxt;

    assign partial_nxt = b_shift[0] ? alu_res[15:0] : alu_a;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_res    <= '0;
            rsp_flag   <= '0;
            acc        <= ACC_INIT;
            ovf_sticky <= 1'b0;
            busy       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
`ifdef ALU_SEQ_MUL_EN
            b_shift    <= '0;
            mul_cnt    <= '0;
`endif
        end else begin
            if (sticky_set) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                        if (cmd_op == OpMul) begin
                            alu_op  <= OpAdd;
                            alu_a   <= '0;
                            alu_b   <= op_a;
                            b_shift <= cmd_b;
                            mul_cnt <= '0;
                            state   <= StMul;
                        end else
`endif
                        begin
                            alu_op <= cmd_op;
                            alu_a  <= op_a;
                            alu_b  <= cmd_b;
                            state  <= StExec;
                        end
                    end
                end
                StExec: begin
                    if (alu_op <= OpNot) begin
                        rsp_res  <= alu_res;
                        rsp_flag <= alu_flag;
                        acc      <= alu_res[15:0];
                    end else begin
                        rsp_res  <= '0;
                        rsp_flag <= 2'b01;
                    end
                    rsp_valid <= 1'b1;
                    state     <= StResp;
                end
`ifdef ALU_SEQ_MUL_EN
                StMul: begin
                    mul_cnt <= mul_cnt + 4'd1;
                    if (mul_cnt == 4'd15) begin
                        rsp_res   <= {1'b0, partial_nxt};
                        rsp_flag  <= {1'b0, partial_nxt == 16'h0000};
                        acc       <= partial_nxt;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end else begin
                        alu_a   <= partial_nxt;
                        alu_b   <= {alu_b[14:0], 1'b0};
                        b_shift <= {1'b0, b_shift[15:1]};
                    end
                end
`endif
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed commands, behavioural ALU, queue-based response check.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        cmd_use_acc = 1'b0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [16:0] alu_res;
    logic [1:0]  alu_flag;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [16:0] rsp_res;
    logic [1:0]  rsp_flag;
    logic [15:0] acc;
    logic        ovf_sticky;
    logic        clr_sticky = 1'b0;
    logic        busy;

    alu_sequencer #(.ACC_INIT(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_flag(rsp_flag),
        .acc(acc), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: signed 17-bit result, flag[0] zero, flag[1] signed overflow on arithmetic.
    logic [16:0] sa, sb, r;
    always_comb begin
        sa = {alu_a[15], alu_a};
        sb = {alu_b[15], alu_b};
        r  = '0;
        case (alu_op)
            4'd0: r = sa + sb;
            4'd1: r = sa - sb;
            4'd2: r = sa + 17'd1;
            4'd3: r = sa - 17'd1;
            4'd4: r = {1'b0, alu_a & alu_b};
            4'd5: r = {1'b0, alu_a | alu_b};
            4'd6: r = {1'b0, alu_a ^ alu_b};
            4'd7: r = {1'b0, ~alu_a};
            default: r = '0;
        endcase
        alu_res  = r;
        alu_flag = {(alu_op < 4'd4) && (r[16] ^ r[15]), r == 17'd0};
    end

    typedef struct {
        logic [16:0] res;
        logic [1:0]  flag;
        logic [15:0] acc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] acc_model = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got res=%h flag=%b, no response expected",
                         rsp_res, rsp_flag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rsp_res !== e.res || rsp_flag !== e.flag || acc !== e.acc) begin
                    n_err++;
                    $display("FAIL rsp: got res=%h flag=%b acc=%h expected res=%h flag=%b acc=%h",
                             rsp_res, rsp_flag, acc, e.res, e.flag, e.acc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string name);
        chk({name, " cmd_ready"}, cmd_ready, 1);
        chk({name, " rsp_valid"}, rsp_valid, 0);
        chk({name, " rsp_res"}, rsp_res, 0);
        chk({name, " rsp_flag"}, rsp_flag, 0);
        chk({name, " acc"}, acc, 0);
        chk({name, " ovf_sticky"}, ovf_sticky, 0);
        chk({name, " busy"}, busy, 0);
        chk({name, " alu_a"}, alu_a, 0);
        chk({name, " alu_b"}, alu_b, 0);
        chk({name, " alu_op"}, alu_op, 0);
    endtask

    // Presents one command; returns one cycle after acceptance (the EXEC / first MUL cycle).
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ua);
        int t = 0;
        while (!cmd_ready && t < 50) begin
            step();
            t++;
        end
        chk("cmd_ready before issue", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        step();
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_use_acc = 1'b0;
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ua, input logic [16:0] er,
                       input logic [1:0] ef, input logic [15:0] eacc, input int elat,
                       input int hold, input logic clr_exec);
        exp_t        e;
        int          lat;
        logic [15:0] exp_a;
        e.res  = er;
        e.flag = ef;
        e.acc  = eacc;
        exp_q.push_back(e);
        exp_a     = ua ? acc_model : a;
        rsp_ready = (hold == 0);
        issue(op, a, b, ua);
        clr_sticky = clr_exec;
        chk({name, " cmd_ready low"}, cmd_ready, 0);
        chk({name, " busy"}, busy, 1);
        if (elat == 2) begin
            chk({name, " alu_op"}, alu_op, op);
            chk({name, " alu_a"}, alu_a, exp_a);
            chk({name, " alu_b"}, alu_b, b);
        end else begin
            chk({name, " mul alu_op"}, alu_op, 0);
            chk({name, " mul alu_a"}, alu_a, 0);
            chk({name, " mul alu_b"}, alu_b, exp_a);
        end
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step();
            clr_sticky = 1'b0;
            lat++;
        end
        clr_sticky = 1'b0;
        chk({name, " latency"}, lat, elat);
        chk({name, " cmd_ready in resp"}, cmd_ready, 0);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'd0;
            cmd_a     = 16'hFFFF;
            cmd_b     = 16'hFFFF;
            step();
            chk({name, " hold rsp_valid"}, rsp_valid, 1);
            chk({name, " hold rsp_res"}, rsp_res, er);
            chk({name, " hold rsp_flag"}, rsp_flag, ef);
            chk({name, " hold cmd_ready"}, cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;
        step();
        chk({name, " idle after rsp"}, cmd_ready, 1);
        chk({name, " rsp_valid dropped"}, rsp_valid, 0);
        acc_model = eacc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset("reset");

        run("add", 4'd0, 16'h0005, 16'h0003, 1'b0, 17'h00008, 2'b00, 16'h0008, 2, 0, 1'b0);
        run("sub_zero", 4'd1, 16'h0005, 16'h0005, 1'b0, 17'h00000, 2'b01, 16'h0000, 2, 0, 1'b0);
        run("inc_acc", 4'd2, 16'h7777, 16'h0000, 1'b1, 17'h00001, 2'b00, 16'h0001, 2, 0, 1'b0);
        run("add_ovf", 4'd0, 16'h8000, 16'hFFFF, 1'b0, 17'h17FFF, 2'b10, 16'h7FFF, 2, 0, 1'b0);
        chk("sticky set", ovf_sticky, 1);
        run("set_vs_clr", 4'd0, 16'h8000, 16'h8000, 1'b0, 17'h10000, 2'b10, 16'h0000, 2, 0,
            1'b1);
        chk("sticky set wins", ovf_sticky, 1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("sticky cleared", ovf_sticky, 0);

        run("hold", 4'd0, 16'h0001, 16'h0002, 1'b0, 17'h00003, 2'b00, 16'h0003, 2, 5, 1'b0);
        run("op12", 4'd12, 16'h1234, 16'h0000, 1'b0, 17'h00000, 2'b01, 16'h0003, 2, 0, 1'b0);
        chk("op12 sticky unchanged", ovf_sticky, 0);

`ifdef ALU_SEQ_MUL_EN
        run("mul_wrap", 4'd8, 16'h0100, 16'h0100, 1'b0, 17'h00000, 2'b01, 16'h0000, 17, 0,
            1'b0);
        run("mul_300x7", 4'd8, 16'd300, 16'd7, 1'b0, 17'h00834, 2'b00, 16'h0834, 17, 0, 1'b0);
        chk("mul sticky", ovf_sticky, 0);
        rsp_ready = 1'b1;
        issue(4'd8, 16'd3, 16'd5, 1'b0);
        repeat (7) step();
        chk("mul8 busy", busy, 1);
        chk("mul8 rsp_valid", rsp_valid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("reset in mul");
        acc_model = 16'h0000;
        repeat (25) step();
        chk("no rsp after mul reset", rsp_valid, 0);
`else
        run("op8_unsup", 4'd8, 16'h0003, 16'h0005, 1'b0, 17'h00000, 2'b01, 16'h0003, 2, 0,
            1'b0);
`endif

        // Abort a pending response with reset; it must never reach the consumer.
        rsp_ready = 1'b0;
        issue(4'd0, 16'h8000, 16'h8000, 1'b0);
        step();
        chk("resp pending", rsp_valid, 1);
        chk("resp sticky", ovf_sticky, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("reset in resp");
        rsp_ready = 1'b1;
        acc_model = 16'h0000;
        repeat (5) step();
        run("after_reset", 4'd6, 16'h00F0, 16'h0FF0, 1'b0, 17'h00F00, 2'b00, 16'h0F00, 2, 0,
            1'b0);

        chk("queue drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-driven controller that owns the 16-bit ALU and sequences operations on it. It accepts one command at a time over a valid/ready handshake and drives the ALU's a/b/op inputs from registered operands. It captures the 17-bit result and 2-bit flags, and returns them over a valid/ready response channel. It also maintains an accumulator and a sticky overflow bit for the SAP datapath.

Parameters:
ACC_INIT, 16'h0000, reset value of the accumulator

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  4  ALU opcode (0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 MUL when enabled)
cmd_a  input  16  operand A
cmd_b  input  16  operand B
cmd_use_acc  input  1  1: operand A taken from accumulator instead of cmd_a
alu_a  output  16  to ALU a
alu_b  output  16  to ALU b
alu_op  output  4  to ALU op
alu_res  input  17  from ALU res (signed)
alu_flag  input  2  from ALU flag ([0] zero, [1] overflow)
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_res  output  17  captured result
rsp_flag  output  2  captured flags
acc  output  16  accumulator
ovf_sticky  output  1  set by any captured overflow flag
clr_sticky  input  1  clears ovf_sticky
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, rsp_res 0, rsp_flag 0, acc ACC_INIT, ovf_sticky 0, busy 0, alu_a/alu_b 0, alu_op 0.
- States: IDLE, EXEC, MUL (optional), RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op, A (acc if cmd_use_acc, else cmd_a) and B.
  - Go to MUL if op==8 and the feature is compiled in; otherwise go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_op/alu_a/alu_b are driven from the latched registers.
  - At the end of the cycle, capture alu_res into rsp_res and alu_flag into rsp_flag, set acc to alu_res[15:0], then go to RESP.
- Unsupported op (9-15, or 8 without the feature):
  - Still passes through EXEC.
  - Forced response: rsp_res=0, rsp_flag=2'b01.
  - acc and ovf_sticky are unchanged.
- RESP:
  - rsp_valid=1.
  - rsp_res and rsp_flag are held stable while !rsp_ready.
  - On rsp_ready, go to IDLE; cmd_ready returns high in the following cycle.
- Latency: command sampled in cycle 0, EXEC in cycle 1, rsp_valid high from cycle 2. Best-case throughput is one command per 3 cycles.
- cmd_ready is low in every state other than IDLE. cmd_* inputs are ignored outside IDLE.
- alu_* outputs hold their last values while in IDLE/RESP.
- ovf_sticky:
  - Set at a capture where the captured flag[1]=1.
  - Cleared by clr_sticky.
  - If set and clear happen in the same cycle, set wins.
- Reset mid-operation (any state): abort to IDLE, discard the in-flight command and any pending response, return all outputs to reset values.
- Arithmetic: the sequencer does no arithmetic of its own except in MUL. Widths are passed through unchanged.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: op 4'd8 is MUL, an unsigned 16x16 multiply whose result is the product modulo 2^16, computed by shift-add on the ALU.
  - Registers: partial (init 0), a_shift (init A), b_shift (init B), 4-bit iteration counter.
  - Runs exactly 16 MUL cycles. Each cycle drives alu_op=ADD, alu_a=partial, alu_b=a_shift.
  - If b_shift[0], partial takes alu_res[15:0]; otherwise partial is unchanged.
  - Each cycle a_shift shifts left by 1 and b_shift shifts right by 1.
  - After iteration 15: rsp_res={1'b0,partial}, rsp_flag={1'b0, partial==0}, acc=partial; go to RESP.
  - rsp_valid is high from cycle 17 after the sample. MUL never sets ovf_sticky.
- Undefined: no MUL state or registers; op 8 is treated as unsupported.

Test Plan:
1. ADD cmd_a=16'h0005, cmd_b=16'h0003 -> rsp_valid in cycle 2, rsp_res=17'h00008, rsp_flag=2'b00, acc=16'h0008, cmd_ready low in cycles 1-2.
2. SUB 16'h0005-16'h0005, then INC with cmd_use_acc=1 -> first rsp_res=0, flag=2'b01; second rsp_res=17'h00001, acc=16'h0001.
3. ADD 16'h8000+16'hFFFF -> rsp_res=17'h17FFF, flag=2'b10, ovf_sticky=1; assert clr_sticky and a capture with overflow in the same cycle -> ovf_sticky stays 1; clr_sticky alone -> 0.
4. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_res stable, cmd_ready=0 and cmd_valid ignored; rsp_ready=1 -> IDLE, next command accepted the following cycle.
5. op=4'd12 with A=16'h1234 -> rsp_res=0, rsp_flag=2'b01, acc unchanged.
6. (ALU_SEQ_MUL_EN) MUL 16'd300*16'd7 -> rsp_valid in cycle 17, rsp_res=17'h00834. MUL 16'h0100*16'h0100 -> rsp_res=0, flag=2'b01. rst in MUL cycle 8 -> IDLE next cycle, no response, acc=ACC_INIT.
